regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-read-port, single-write-port general-purpose register file with optional hardwired-zero entry, optional same-cycle write-to-read bypass, and an integrated per-register busy scoreboard. It sits between decode/issue and writeback in the npc core. Issue marks destination registers pending. Writeback commits data and clears the pending bit. Readers get data and a busy flag for hazard stalls.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NR_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and busy sets.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  write enable (writeback).
- waddr  in  ADDR_WIDTH  write index.
- wdata  in  DATA_WIDTH  write data.
- raddr  in  NR_READ*ADDR_WIDTH  read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_READ*DATA_WIDTH  read data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- rbusy  out  NR_READ  busy flag for each read port.
- busy_set  in  1  mark busy_addr pending (issue).
- busy_addr  in  ADDR_WIDTH  destination index being issued.
- busy_flush  in  1  clear all pending bits (pipeline flush).
- busy_any  out  1  OR of all pending bits.

## Operation
- Array: 2**ADDR_WIDTH x DATA_WIDTH registers plus a 2**ADDR_WIDTH pending-bit vector.
- Reset: every entry is set to 0 and every pending bit is cleared on the rst edge. Outputs after reset: rdata = 0 on all ports, rbusy = 0, busy_any = 0. While rst is high, wen, busy_set and busy_flush are ignored.
- Write: if wen, rf[waddr] <= wdata and pending[waddr] <= 0. When ZERO_REG=1 and waddr=0, the write is dropped.
- Read (combinational): rdata_i = rf[raddr_i]. When ZERO_REG=1 and raddr_i=0, rdata_i = 0 and rbusy_i = 0.
- Bypass (BYPASS=1): if wen and waddr == raddr_i and the address is not the zero register, then rdata_i = wdata and rbusy_i = 0 in the same cycle. With BYPASS=0, the read returns the old value and rbusy_i = pending[raddr_i].
- Scoreboard next-state, in priority order:
  1. busy_flush clears all bits.
  2. wen clears pending[waddr].
  3. busy_set sets pending[busy_addr]; set wins over the clear and the flush in the same cycle, because it comes from the newer owner.
  - busy_set on entry 0 with ZERO_REG=1 is ignored.
- busy_any reflects the registered pending vector and is not bypassed.

## Timing
- Read latency is 0 cycles (combinational from raddr, and from wen/waddr/wdata when BYPASS=1).
- Write latency is 1 cycle to the array. With BYPASS=1, the write is visible on reads in the same cycle.
- busy_set is visible on rbusy/busy_any on the cycle after the edge.
- wen clear is visible the next cycle. With BYPASS=1, rbusy already reads 0 in the write cycle.
- Same-cycle wen and busy_set to the same address: data is written and the bit ends set, so a reader sees busy next cycle.
- Multiple read ports may use identical addresses; each gets identical results.
- A reset asserted in any cycle, mid-stream, discards that cycle's write and set. The next cycle shows all-zero state.

## Structure
- A shared package holds the default ADDR_WIDTH/DATA_WIDTH constants, the register-index typedef, and a named constant for the zero-register index.
- Natural sub-module: regfile_scoreboard, which holds the pending-bit vector, the set/clear/flush priority, busy_any, and per-port busy lookup. The top holds the data array, bypass mux and zero-register masking.
- Read ports are generated with a generate loop over NR_READ.

## Test plan
- Reset, then read all 32 entries on both ports -> every rdata = 0, rbusy = 0, busy_any = 0.
- Write x5=0xDEADBEEF with raddr0=5 in the same cycle -> BYPASS=1: rdata0=0xDEADBEEF that cycle. BYPASS=0: old value 0, then 0xDEADBEEF next cycle.
- Write x0=0x1234 and busy_set x0 -> rdata for x0 = 0, rbusy = 0, busy_any stays 0 (ZERO_REG=1).
- busy_set x7; next cycle raddr1=7 -> rbusy1=1, busy_any=1. Then wen x7=0x55 -> rbusy1=0 in the same cycle (bypass) and rdata1=0x55.
- Same cycle: wen x3=0xA, busy_set x3, busy_flush -> next cycle rf[3]=0xA, pending[3]=1, all other pending bits 0.
- Fill x1..x31 with index values, set x9 pending, then assert rst mid-write with wen x2=0xFF -> next cycle all entries read 0, rbusy=0, x2 ≠ 0xFF.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the npc register file and its busy scoreboard.
package regfile_sb_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;

    // Index of the hardwired-zero entry when ZERO_REG is enabled.
    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-bit scoreboard.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wen, waddr      writeback clears pending[waddr]
//   busy_set/addr   issue marks busy_addr pending
//   busy_flush      clears every pending bit
//   raddr           packed read indices, one per read port
//   rbusy           per-port busy lookup (bypassed by a same-cycle write)
//   busy_any        OR of the registered pending vector
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NR_READ    = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic                          busy_set,
    input  logic [ADDR_WIDTH-1:0]         busy_addr,
    input  logic                          busy_flush,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ-1:0]            rbusy,
    output logic                          busy_any
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_IDX));
    endfunction

    // Flush, then writeback clear, then issue set: the set comes from the newest owner.
    always_comb begin
        pending_nxt = pending;
        if (busy_flush) begin
            pending_nxt = '0;
        end
        if (wen) begin
            pending_nxt[waddr] = 1'b0;
        end
        if (busy_set && !is_zero(busy_addr)) begin
            pending_nxt[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy_any = |pending;

    // A write in reset is discarded, so it must not bypass the busy lookup either.
    generate
        for (genvar gi = 0; gi < int'(NR_READ); gi++) begin : g_rbusy
            logic [ADDR_WIDTH-1:0] ra;
            logic                  byp_hit;
            assign ra      = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign byp_hit = (BYPASS != 0) && wen && !rst && (waddr == ra);
            assign rbusy[gi] = (is_zero(ra) || byp_hit) ? 1'b0 : pending[ra];
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with zero-register masking,
// same-cycle write-to-read bypass and an integrated busy scoreboard.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wen/waddr/wdata writeback port
//   raddr, rdata    packed read indices / read data (combinational)
//   rbusy           per-port hazard flag
//   busy_set/addr   issue-time pending mark
//   busy_flush      clear all pending bits
//   busy_any        any register pending
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NR_READ    = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rbusy,
    input  logic                          busy_set,
    input  logic [ADDR_WIDTH-1:0]         busy_addr,
    input  logic                          busy_flush,
    output logic                          busy_any
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_IDX));
    endfunction

    // Data array; writes to the hardwired-zero entry are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf[i] <= '0;
            end
        end else if (wen && !is_zero(waddr)) begin
            rf[waddr] <= wdata;
        end
    end

    // Read ports: zero masking first, then bypass, then the array.
    generate
        for (genvar gi = 0; gi < int'(NR_READ); gi++) begin : g_read
            logic [ADDR_WIDTH-1:0] ra;
            logic                  byp_hit;
            assign ra      = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign byp_hit = (BYPASS != 0) && wen && !rst && (waddr == ra);
            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
                is_zero(ra) ? '0 : (byp_hit ? wdata : rf[ra]);
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_READ    (NR_READ),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .waddr      (waddr),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .busy_flush (busy_flush),
        .raddr      (raddr),
        .rbusy      (rbusy),
        .busy_any   (busy_any)
    );

endmodule
